// File: rtl/arbitro_ativos.sv
// Round-robin arbiter feeding desativar/atualizar requests into the single-request
// active-node manager; desativar wins over atualizar, atualizar waits for a free NA.
module arbitro_ativos #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CUSTO_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_desativar_in,
    input  logic [NUM_REQ-1:0]                 req_atualizar_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_endereco_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_anterior_in,
    input  logic [NUM_REQ*CUSTO_WIDTH-1:0]     req_menor_vizinho_in,
    input  logic [NUM_REQ*DISTANCIA_WIDTH-1:0] req_distancia_in,
    output logic [NUM_REQ-1:0]                 ack_out,
    output logic                               desativar_out,
    output logic                               atualizar_out,
    output logic [ADDR_WIDTH-1:0]              endereco_out,
    output logic [ADDR_WIDTH-1:0]              anterior_out,
    output logic [CUSTO_WIDTH-1:0]             menor_vizinho_out,
    output logic [DISTANCIA_WIDTH-1:0]         distancia_out,
    input  logic                               ga_ocupado_in,
    input  logic                               ga_buffers_cheios_in,
    output logic                               ocupado_out,
    output logic [$clog2(NUM_REQ)-1:0]         concedido_out,
    output logic                               timeout_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]    WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic [NUM_REQ-1:0] UM    = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMITIR,
        ST_AGUARDA_INICIO,
        ST_AGUARDA_FIM,
        ST_CONCLUIR
    } estado_t;

    estado_t                    estado_q;
    logic [IDX_W-1:0]           ptr_q;
    logic [NUM_REQ-1:0]         mask_q;
    logic [WD_W-1:0]            wd_q;
    logic                       timeout_q;
    logic [NUM_REQ-1:0]         ack_q;
    logic                       des_q;
    logic                       atu_q;
    logic                       ocupado_q;
    logic [IDX_W-1:0]           concedido_q;
    logic [ADDR_WIDTH-1:0]      endereco_q;
    logic [ADDR_WIDTH-1:0]      anterior_q;
    logic [CUSTO_WIDTH-1:0]     custo_q;
    logic [DISTANCIA_WIDTH-1:0] distancia_q;

    logic [NUM_REQ-1:0]         eleg_des;
    logic [NUM_REQ-1:0]         eleg_atu;
    logic [NUM_REQ-1:0]         candidatos;
    logic                       usa_des;
    logic                       achou_d;
    logic [IDX_W-1:0]           vencedor_d;
    logic [ADDR_WIDTH-1:0]      endereco_d;
    logic [ADDR_WIDTH-1:0]      anterior_d;
    logic [CUSTO_WIDTH-1:0]     custo_d;
    logic [DISTANCIA_WIDTH-1:0] distancia_d;

    // A requester raising both lines counts only as desativar.
    assign eleg_des   = req_desativar_in & ~mask_q;
    assign eleg_atu   = req_atualizar_in & ~req_desativar_in & ~mask_q
                        & {NUM_REQ{~ga_buffers_cheios_in}};
    assign usa_des    = |eleg_des;
    assign candidatos = usa_des ? eleg_des : eleg_atu;

    always_comb begin
        int idx;
        idx         = 0;
        achou_d     = 1'b0;
        vencedor_d  = ptr_q;
        endereco_d  = '0;
        anterior_d  = '0;
        custo_d     = '0;
        distancia_d = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!achou_d && candidatos[idx]) begin
                achou_d     = 1'b1;
                vencedor_d  = IDX_W'(idx);
                endereco_d  = req_endereco_in[ADDR_WIDTH*idx +: ADDR_WIDTH];
                anterior_d  = req_anterior_in[ADDR_WIDTH*idx +: ADDR_WIDTH];
                custo_d     = req_menor_vizinho_in[CUSTO_WIDTH*idx +: CUSTO_WIDTH];
                distancia_d = req_distancia_in[DISTANCIA_WIDTH*idx +: DISTANCIA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= ST_IDLE;
            ptr_q       <= '0;
            mask_q      <= '0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            ack_q       <= '0;
            des_q       <= 1'b0;
            atu_q       <= 1'b0;
            ocupado_q   <= 1'b0;
            concedido_q <= '0;
            endereco_q  <= '0;
            anterior_q  <= '0;
            custo_q     <= '0;
            distancia_q <= '0;
        end else begin
            ack_q <= '0;
            des_q <= 1'b0;
            atu_q <= 1'b0;
            case (estado_q)
                ST_IDLE: begin
                    mask_q <= '0;
                    if (!ga_ocupado_in && achou_d) begin
                        estado_q    <= ST_EMITIR;
                        ptr_q       <= vencedor_d;
                        concedido_q <= vencedor_d;
                        endereco_q  <= endereco_d;
                        anterior_q  <= anterior_d;
                        custo_q     <= custo_d;
                        distancia_q <= distancia_d;
                        des_q       <= usa_des;
                        atu_q       <= ~usa_des;
                        ocupado_q   <= 1'b1;
                        wd_q        <= '0;
                    end
                end
                ST_EMITIR: estado_q <= ST_AGUARDA_INICIO;
                ST_AGUARDA_INICIO, ST_AGUARDA_FIM: begin
                    // Watchdog saturates; the FSM keeps waiting after it fires.
                    if (wd_q != WD_MAX) wd_q <= wd_q + 1'b1;
                    if (wd_q == WD_MAX - 1'b1) timeout_q <= 1'b1;
                    if (estado_q == ST_AGUARDA_INICIO) begin
                        if (ga_ocupado_in) estado_q <= ST_AGUARDA_FIM;
                    end else if (!ga_ocupado_in) begin
                        estado_q <= ST_CONCLUIR;
                        ack_q    <= UM << concedido_q;
                    end
                end
                ST_CONCLUIR: begin
                    mask_q    <= UM << concedido_q;
                    ocupado_q <= 1'b0;
                    estado_q  <= ST_IDLE;
                end
                default: estado_q <= ST_IDLE;
            endcase
        end
    end

    assign ack_out           = ack_q;
    assign desativar_out     = des_q;
    assign atualizar_out     = atu_q;
    assign endereco_out      = endereco_q;
    assign anterior_out      = anterior_q;
    assign menor_vizinho_out = custo_q;
    assign distancia_out     = distancia_q;
    assign ocupado_out       = ocupado_q;
    assign concedido_out     = concedido_q;
    assign timeout_out       = timeout_q;

endmodule

// File: tb/tb_arbitro_ativos.sv
// Scoreboard bench for arbitro_ativos: expected grants are queued as requests are
// raised and matched against each command pulse, with a simple manager model.
module tb_arbitro_ativos;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_desativar_in;
    logic [N-1:0]   req_atualizar_in;
    logic [N*5-1:0] req_endereco_in;
    logic [N*5-1:0] req_anterior_in;
    logic [N*4-1:0] req_menor_vizinho_in;
    logic [N*5-1:0] req_distancia_in;
    logic [N-1:0]   ack_out;
    logic           desativar_out;
    logic           atualizar_out;
    logic [4:0]     endereco_out;
    logic [4:0]     anterior_out;
    logic [3:0]     menor_vizinho_out;
    logic [4:0]     distancia_out;
    logic           ga_ocupado_in;
    logic           ga_buffers_cheios_in;
    logic           ocupado_out;
    logic [1:0]     concedido_out;
    logic           timeout_out;

    int checks   = 0;
    int failures = 0;
    int busy_len = 3;
    int last_idx = 0;
    logic [24:0] sb_q[$];

    arbitro_ativos dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_desativar_in     (req_desativar_in),
        .req_atualizar_in     (req_atualizar_in),
        .req_endereco_in      (req_endereco_in),
        .req_anterior_in      (req_anterior_in),
        .req_menor_vizinho_in (req_menor_vizinho_in),
        .req_distancia_in     (req_distancia_in),
        .ack_out              (ack_out),
        .desativar_out        (desativar_out),
        .atualizar_out        (atualizar_out),
        .endereco_out         (endereco_out),
        .anterior_out         (anterior_out),
        .menor_vizinho_out    (menor_vizinho_out),
        .distancia_out        (distancia_out),
        .ga_ocupado_in        (ga_ocupado_in),
        .ga_buffers_cheios_in (ga_buffers_cheios_in),
        .ocupado_out          (ocupado_out),
        .concedido_out        (concedido_out),
        .timeout_out          (timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_pl(input int i, input logic [4:0] a, input logic [4:0] ant,
                          input logic [3:0] c, input logic [4:0] d);
        req_endereco_in[5*i +: 5]      = a;
        req_anterior_in[5*i +: 5]      = ant;
        req_menor_vizinho_in[4*i +: 4] = c;
        req_distancia_in[5*i +: 5]     = d;
    endtask

    function automatic logic [24:0] exp_word(input bit des, input int i);
        return {des, ~des, 3'(i), req_endereco_in[5*i +: 5], req_anterior_in[5*i +: 5],
                req_menor_vizinho_in[4*i +: 4], req_distancia_in[5*i +: 5]};
    endfunction

    task automatic wait_acks(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack_out != '0) got++;
        end
        if (got < n) chk("ack_wait", 64'(got), 64'(n));
    endtask

    task automatic wait_pulse(input int budget);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(desativar_out || atualizar_out) && cyc < budget);
        if (!(desativar_out || atualizar_out)) chk("pulse_wait", 0, 1);
    endtask

    // Manager model: busy starts the cycle after the pulse and lasts busy_len cycles.
    initial begin
        ga_ocupado_in = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (desativar_out || atualizar_out)) begin
                @(negedge clk);
                ga_ocupado_in = 1'b1;
                repeat (busy_len) @(negedge clk);
                ga_ocupado_in = 1'b0;
            end
        end
    end

    // Monitor: every pulse pops one expected grant; every ack must match it.
    initial begin
        logic [24:0] e;
        logic [24:0] obs;
        forever begin
            @(negedge clk);
            if (desativar_out || atualizar_out) begin
                chk("pulse_excl", 64'(desativar_out & atualizar_out), 0);
                obs = {desativar_out, atualizar_out, 1'b0, concedido_out, endereco_out,
                       anterior_out, menor_vizinho_out, distancia_out};
                if (sb_q.size() == 0) begin
                    chk("pulse_unexpected", 64'(obs), 0);
                end else begin
                    e = sb_q.pop_front();
                    last_idx = int'(e[21:19]);
                    chk("grant", 64'(obs), 64'(e));
                end
            end
            if (ack_out != '0) chk("ack", 64'(ack_out), 64'(4'b0001 << last_idx));
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n                = 1'b0;
        req_desativar_in     = '0;
        req_atualizar_in     = '0;
        ga_buffers_cheios_in = 1'b0;
        set_pl(0, 5'd3,  5'd1,  4'd2,  5'd7);
        set_pl(1, 5'd12, 5'd4,  4'd5,  5'd10);
        set_pl(2, 5'd9,  5'd6,  4'd9,  5'd17);
        set_pl(3, 5'd31, 5'd30, 4'd15, 5'd31);
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack_out), 0);
        chk("rst_des", 64'(desativar_out), 0);
        chk("rst_atu", 64'(atualizar_out), 0);
        chk("rst_end", 64'(endereco_out), 0);
        chk("rst_ant", 64'(anterior_out), 0);
        chk("rst_custo", 64'(menor_vizinho_out), 0);
        chk("rst_dist", 64'(distancia_out), 0);
        chk("rst_ocup", 64'(ocupado_out), 0);
        chk("rst_conc", 64'(concedido_out), 0);
        chk("rst_tmo", 64'(timeout_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single desativar from requester 2, manager busy 3 cycles
        sb_q.push_back(exp_word(1, 2));
        req_desativar_in[2] = 1'b1;
        wait_acks(1, 100);
        @(negedge clk);
        req_desativar_in[2] = 1'b0;
        chk("hold_conc", 64'(concedido_out), 2);
        chk("hold_end", 64'(endereco_out), 9);
        chk("idle_ocup", 64'(ocupado_out), 0);

        // Desativar outranks a simultaneous atualizar
        sb_q.push_back(exp_word(1, 3));
        sb_q.push_back(exp_word(0, 0));
        req_atualizar_in[0] = 1'b1;
        req_desativar_in[3] = 1'b1;
        wait_acks(1, 100);
        @(negedge clk);
        req_desativar_in[3] = 1'b0;
        wait_acks(1, 100);
        @(negedge clk);
        req_atualizar_in[0] = 1'b0;

        // Round-robin among four continuous atualizar requesters
        busy_len = 1;
        for (int r = 0; r < 2; r++)
            for (int i = 1; i <= N; i++) sb_q.push_back(exp_word(0, i % N));
        req_atualizar_in = '1;
        wait_acks(8, 200);
        @(negedge clk);
        req_atualizar_in = '0;

        // Just-acked requester is skipped for one idle cycle
        sb_q.push_back(exp_word(1, 1));
        sb_q.push_back(exp_word(1, 1));
        req_desativar_in[1] = 1'b1;
        wait_acks(1, 100);
        @(negedge clk);
        chk("mask_idle1", 64'(ocupado_out), 0);
        @(negedge clk);
        chk("mask_idle2", 64'(ocupado_out), 0);
        @(negedge clk);
        chk("mask_regrant", 64'(desativar_out), 1);
        wait_acks(1, 100);
        @(negedge clk);
        req_desativar_in[1] = 1'b0;

        // Atualizar withheld while buffers are full
        ga_buffers_cheios_in = 1'b1;
        req_atualizar_in[1]  = 1'b1;
        repeat (10) @(negedge clk);
        chk("full_hold", 64'(ocupado_out), 0);
        sb_q.push_back(exp_word(0, 1));
        ga_buffers_cheios_in = 1'b0;
        wait_acks(1, 100);
        @(negedge clk);
        req_atualizar_in[1] = 1'b0;

        // Watchdog: manager busy 70 cycles
        chk("wd_before", 64'(timeout_out), 0);
        busy_len = 70;
        sb_q.push_back(exp_word(1, 0));
        req_desativar_in[0] = 1'b1;
        wait_pulse(100);
        repeat (60) @(negedge clk);
        chk("wd_early", 64'(timeout_out), 0);
        repeat (8) @(negedge clk);
        chk("wd_during", 64'(timeout_out), 1);
        chk("wd_waiting", 64'(ocupado_out), 1);
        wait_acks(1, 200);
        @(negedge clk);
        req_desativar_in[0] = 1'b0;
        chk("wd_set", 64'(timeout_out), 1);
        busy_len = 3;
        sb_q.push_back(exp_word(1, 2));
        req_desativar_in[2] = 1'b1;
        wait_acks(1, 100);
        @(negedge clk);
        req_desativar_in[2] = 1'b0;
        chk("wd_sticky", 64'(timeout_out), 1);

        // Reset in the middle of a transaction
        busy_len = 10;
        sb_q.push_back(exp_word(1, 2));
        req_desativar_in[2] = 1'b1;
        wait_pulse(100);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ocup", 64'(ocupado_out), 0);
        chk("mid_rst_tmo", 64'(timeout_out), 0);
        chk("mid_rst_end", 64'(endereco_out), 0);
        chk("mid_rst_conc", 64'(concedido_out), 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_ack", 64'(ack_out), 0);
        end
        rst_n = 1'b1;
        sb_q.push_back(exp_word(1, 2));
        wait_acks(1, 100);
        @(negedge clk);
        req_desativar_in[2] = 1'b0;

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
